// File: rtl/simple_dir2_capture_if.sv
// Point-to-point `simple` link: dir1 drives simple1 and reads simple2,
// dir2 observes simple1 and drives simple2.
interface simple #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] simple1;
  logic [WIDTH-1:0] simple2;

  modport dir1 (output simple1, input simple2);
  modport dir2 (input simple1, output simple2);
endinterface

// File: rtl/simple_dir2_capture.sv
// Change-capture FIFO on the dir2 side of a `simple` link; head shown on simple2.
// Optional push/drop statistics enabled by defining SIMPLE_DIR2_CAPTURE_STATS_EN.
module simple_dir2_capture #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] EMPTY_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  simple.dir2                      conn,
  input  logic                     adv,
  input  logic                     clr,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef SIMPLE_DIR2_CAPTURE_STATS_EN
  ,
  output logic [15:0]              push_cnt,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] prev_q;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             chg, push, pop, drop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign overflow = overflow_q;

  // Popping from a full FIFO frees the slot the incoming push lands in.
  assign chg  = (conn.simple1 != prev_q);
  assign pop  = adv && !empty;
  assign push = chg && (!full || pop);
  assign drop = chg && full && !pop;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (drop)     overflow_d = 1'b1;
    else if (clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_q     <= conn.simple1;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is left unreset; it is masked by EMPTY_VAL whenever empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= conn.simple1;
  end

  assign conn.simple2 = empty ? EMPTY_VAL : mem_q[rd_ptr_q];

`ifdef SIMPLE_DIR2_CAPTURE_STATS_EN
  logic [15:0] push_cnt_q;
  logic [7:0]  drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push) push_cnt_q <= push_cnt_q + 16'd1;
      if (clr)                               drop_cnt_q <= drop ? 8'd1 : 8'd0;
      else if (drop && drop_cnt_q != 8'hFF)  drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign push_cnt = push_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_simple_dir2_capture.sv
// Directed bench for simple_dir2_capture: each task drives one scenario and
// compares outputs against hand-computed values on the falling edge.
module tb_simple_dir2_capture;

  logic        clk;
  logic        rst;
  logic        adv;
  logic        clr;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic        overflow;
`ifdef SIMPLE_DIR2_CAPTURE_STATS_EN
  logic [15:0] push_cnt;
  logic [7:0]  drop_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  simple #(.WIDTH(32)) bus ();

  simple_dir2_capture #(.WIDTH(32), .DEPTH(4), .EMPTY_VAL(32'h0)) dut (
    .clk      (clk),
    .rst      (rst),
    .conn     (bus.dir2),
    .adv      (adv),
    .clr      (clr),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
`ifdef SIMPLE_DIR2_CAPTURE_STATS_EN
    ,
    .push_cnt (push_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply inputs, take one rising edge, return at the falling edge
  task automatic cyc(input logic [31:0] d, input logic a, input logic c);
    bus.simple1 = d;
    adv         = a;
    clr         = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.simple1 = 32'h0;
    adv = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.simple1 = 32'h0;
    adv = 1'b0;
    clr = 1'b0;
    rst = 1'b0;
    #2;
    tests_run++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0 || overflow !== 1'b0 ||
        bus.simple2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_state: empty=%b full=%b count=%0d ovf=%b head=%h, want 1 0 0 0 0",
               empty, full, count, overflow, bus.simple2);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_hold();
    cyc(32'h55AA, 1'b0, 1'b0);
    tests_run++;
    if (bus.simple2 !== 32'h0000_55AA || count !== 3'd1) begin
      tests_failed++;
      $display("FAIL hold_first: head=%h count=%0d, want 000055aa 1", bus.simple2, count);
    end
    for (int i = 0; i < 9; i++) cyc(32'h55AA, 1'b0, 1'b0);
    tests_run++;
    if (count !== 3'd1 || empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_single_push: count=%0d empty=%b, want 1 0", count, empty);
    end
    cyc(32'h55AA, 1'b1, 1'b0);
    tests_run++;
    if (empty !== 1'b1 || bus.simple2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL hold_drain: empty=%b head=%h, want 1 0", empty, bus.simple2);
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] exp_head [5];
    exp_head[0] = 32'd2; exp_head[1] = 32'd3; exp_head[2] = 32'd4; exp_head[3] = 32'd0;
    for (int v = 1; v <= 4; v++) cyc(32'(v), 1'b0, 1'b0);
    tests_run++;
    if (full !== 1'b1 || count !== 3'd4 || bus.simple2 !== 32'd1) begin
      tests_failed++;
      $display("FAIL fill: full=%b count=%0d head=%h, want 1 4 1", full, count, bus.simple2);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(32'd4, 1'b1, 1'b0);
      tests_run++;
      if (bus.simple2 !== exp_head[i]) begin
        tests_failed++;
        $display("FAIL drain_step%0d: head=%h, want %h", i, bus.simple2, exp_head[i]);
      end
    end
    tests_run++;
    if (empty !== 1'b1 || count !== 3'd0) begin
      tests_failed++;
      $display("FAIL drain_empty: empty=%b count=%0d, want 1 0", empty, count);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_head [4];
    exp_head[0] = 32'd3; exp_head[1] = 32'd4; exp_head[2] = 32'd6; exp_head[3] = 32'd0;
    for (int v = 1; v <= 4; v++) cyc(32'(v), 1'b0, 1'b0);
    cyc(32'd5, 1'b0, 1'b0);
    tests_run++;
    if (overflow !== 1'b1 || count !== 3'd4 || bus.simple2 !== 32'd1) begin
      tests_failed++;
      $display("FAIL drop: ovf=%b count=%0d head=%h, want 1 4 1", overflow, count, bus.simple2);
    end
    cyc(32'd6, 1'b1, 1'b0);
    tests_run++;
    if (overflow !== 1'b1 || count !== 3'd4 || full !== 1'b1 || bus.simple2 !== 32'd2) begin
      tests_failed++;
      $display("FAIL full_push_pop: ovf=%b count=%0d full=%b head=%h, want 1 4 1 2",
               overflow, count, full, bus.simple2);
    end
    cyc(32'd6, 1'b0, 1'b1);
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr: ovf=%b, want 0", overflow);
    end
    cyc(32'd7, 1'b0, 1'b1);
    tests_run++;
    if (overflow !== 1'b1 || count !== 3'd4) begin
      tests_failed++;
      $display("FAIL clr_vs_drop: ovf=%b count=%0d, want 1 4", overflow, count);
    end
    cyc(32'd7, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(32'd7, 1'b1, 1'b0);
      tests_run++;
      if (bus.simple2 !== exp_head[i]) begin
        tests_failed++;
        $display("FAIL ovf_drain%0d: head=%h, want %h", i, bus.simple2, exp_head[i]);
      end
    end
    tests_run++;
    if (overflow !== 1'b0 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_final: ovf=%b empty=%b, want 0 1", overflow, empty);
    end
  endtask

  task automatic test_empty_push_pop();
    cyc(32'd8, 1'b1, 1'b0);
    tests_run++;
    if (count !== 3'd1 || bus.simple2 !== 32'd8) begin
      tests_failed++;
      $display("FAIL empty_push_pop: count=%0d head=%h, want 1 8", count, bus.simple2);
    end
    cyc(32'd8, 1'b1, 1'b0);
    tests_run++;
    if (empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_pop_ignored: empty=%b, want 1", empty);
    end
    cyc(32'd8, 1'b1, 1'b0);
    tests_run++;
    if (count !== 3'd0 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL underflow: count=%0d empty=%b, want 0 1", count, empty);
    end
  endtask

  task automatic test_reset_mid();
    cyc(32'd10, 1'b0, 1'b0);
    cyc(32'd11, 1'b0, 1'b0);
    cyc(32'd12, 1'b0, 1'b0);
    tests_run++;
    if (count !== 3'd3) begin
      tests_failed++;
      $display("FAIL mid_prefill: count=%0d, want 3", count);
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (empty !== 1'b1 || count !== 3'd0 || bus.simple2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_reset: empty=%b count=%0d head=%h, want 1 0 0",
               empty, count, bus.simple2);
    end
    @(negedge clk);
    rst = 1'b1;
    cyc(32'd0, 1'b0, 1'b0);
    tests_run++;
    if (count !== 3'd0 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_zero: count=%0d empty=%b, want 0 1", count, empty);
    end
    cyc(32'd9, 1'b0, 1'b0);
    tests_run++;
    if (count !== 3'd1 || bus.simple2 !== 32'd9) begin
      tests_failed++;
      $display("FAIL post_reset_push: count=%0d head=%h, want 1 9", count, bus.simple2);
    end
  endtask

`ifdef SIMPLE_DIR2_CAPTURE_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 70000; i++) cyc((i % 2 == 0) ? 32'd1 : 32'd2, 1'b1, 1'b0);
    tests_run++;
    if (push_cnt !== 16'd4464) begin
      tests_failed++;
      $display("FAIL push_cnt_wrap: push_cnt=%0d, want 4464", push_cnt);
    end
    do_reset();
    for (int v = 1; v <= 4; v++) cyc(32'(v), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cyc(32'(100 + i), 1'b0, 1'b0);
    tests_run++;
    if (drop_cnt !== 8'hFF || push_cnt !== 16'd4) begin
      tests_failed++;
      $display("FAIL drop_cnt_sat: drop_cnt=%h push_cnt=%0d, want ff 4", drop_cnt, push_cnt);
    end
    cyc(32'd399, 1'b0, 1'b1);
    tests_run++;
    if (drop_cnt !== 8'h00) begin
      tests_failed++;
      $display("FAIL drop_cnt_clr: drop_cnt=%h, want 00", drop_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    @(negedge clk);
    test_hold();
    test_fill_drain();
    test_overflow();
    test_empty_push_pop();
    test_reset_mid();
`ifdef SIMPLE_DIR2_CAPTURE_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/simple_dir2_capture.md
Name: simple_dir2_capture

Overview:
- Consumer-side stage for the `simple` interface; connects through modport dir2.
- Watches `conn.simple1` for value changes and queues each new value in a small FIFO.
- Presents the FIFO head on `conn.simple2`, which the dir1-side `submodule`/`subsubmodule` reads back as `rslt`.
- Sits on the opposite side of the same `simple` instance from `submodule`.

Parameters:
- WIDTH, 32: data width; must match the `simple` instance's WIDTH.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- EMPTY_VAL, 0: value driven on `conn.simple2` while the FIFO is empty.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- conn  interface  simple.dir2  interface port:
  - conn.simple1  input  WIDTH  observed data.
  - conn.simple2  output  WIDTH  FIFO head.
- adv  input  1  pop request; consumes the head entry.
- clr  input  1  synchronous clear of the `overflow` flag only.
- empty  output  1  FIFO holds 0 entries.
- full  output  1  FIFO holds DEPTH entries.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky flag: a change was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0, asynchronous):
  - Clears rd_ptr, wr_ptr, count, overflow and the prev register (prev=0).
  - empty=1, full=0, count=0, overflow=0, conn.simple2=EMPTY_VAL, all effective immediately without a clock edge.
  - Reset deassertion is synchronous to clk.
- Change detect: chg = (conn.simple1 != prev). prev <= conn.simple1 on every clock edge, whether or not the push is accepted.
- Push condition: chg && (!full || pop). Writes mem[wr_ptr] <= conn.simple1 and advances wr_ptr (mod DEPTH).
- Pop condition: adv && !empty. Advances rd_ptr (mod DEPTH).
- adv while empty is ignored; no underflow flag.
- count rule:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on push+pop, or on neither.
- Full with simultaneous push and pop: both accepted, count stays DEPTH, no overflow.
- Empty with chg and adv in the same cycle: pop ignored, push accepted, count becomes 1.
- Dropped push (chg && full && !pop): overflow <= 1. The flag holds until clr=1 or reset.
  - clr and a new drop in the same cycle: overflow stays 1 (set wins).
- conn.simple2 = empty ? EMPTY_VAL : mem[rd_ptr]. Combinational from registers only; no path from conn.simple1 to conn.simple2.
- Latency: a change present on conn.simple1 before edge N appears on conn.simple2 just after edge N, provided the FIFO was empty.
- empty, full and count are combinational from count. Pointers wrap modulo DEPTH; count never exceeds DEPTH.
- mem contents are not reset; they are never observable while empty.
- Reset mid-operation discards all queued entries. The first non-zero conn.simple1 after reset is treated as a change.

Optional Feature:
- Macro: SIMPLE_DIR2_CAPTURE_STATS_EN.
- Defined:
  - Adds output port `push_cnt` (16 bits), reset 0.
  - Increments once per accepted push and wraps 0xFFFF -> 0.
  - Also adds output `drop_cnt` (8 bits), reset 0, which increments per dropped push and saturates at 0xFF.
  - clr also zeroes drop_cnt.
- Not defined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then conn.simple1 held at 32'h55AA for 10 cycles -> exactly one push; count=1; conn.simple2=32'h0000_55AA one cycle after the first edge; empty=0.
- Drive 1,2,3,4 on consecutive cycles, adv=0 -> full=1, count=4. Then pulse adv four times -> conn.simple2 steps 1,2,3,4 then EMPTY_VAL; empty=1.
- FIFO full, then drive 5 with adv=0 -> overflow=1, count=4, head still 1. Drive 6 with adv=1 -> push accepted, count=4, overflow stays 1. clr=1 -> overflow=0.
- FIFO empty, drive 7 with adv=1 in the same cycle -> count=1, conn.simple2=7.
- Three entries queued, then rst=0 asserted mid-cycle -> empty=1, count=0 and conn.simple2=EMPTY_VAL before the next clk edge. After release, driving 0 causes no push; driving 9 pushes 9.
- With SIMPLE_DIR2_CAPTURE_STATS_EN defined:
  - 70000 alternating changes with adv=1 every cycle -> push_cnt = 70000 mod 65536 = 4464.
  - 300 drops -> drop_cnt=0xFF.
